lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Load/store unit between the execute stage and the data-memory port.
- Accepts one memory operation per handshake, in the same 3-bit op encoding the data memory uses.
- Produces word-aligned, byte-masked memory requests and waits for memory acknowledge with a watchdog timeout.
- Returns sign- or zero-extended load data, or an error, through a valid/ready response channel.

Parameters:
TIMEOUT, 255, max cycles spent in ISSUE+WAIT without mem_ack before error; legal range 1..65535
CNT_W, 16, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents an operation
req_ready  out  1  unit can accept an operation
req_we  in  1  1=store, 0=load
req_ctr  in  3  000 b-signed, 001 h-signed, 010 w, 100 b-unsigned, 101 h-unsigned
req_addr  in  32  byte address
req_wdata  in  32  store data, value in low bits
mem_req  out  1  memory request strobe
mem_we  out  1  memory write enable
mem_addr  out  32  word-aligned address
mem_wmask  out  4  byte-lane write strobes
mem_wdata  out  32  lane-shifted store data
mem_ack  in  1  memory completion; mem_rdata valid same cycle
mem_rdata  in  32  raw word read
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_data  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal op, or timeout

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: state IDLE; watchdog counter 0; latched request cleared.
  - Outputs: req_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_wmask=0, mem_wdata=0; resp_valid=0, resp_data=0, resp_err=0.
  - Reset asserted mid-operation aborts immediately: mem_req drops asynchronously and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE. req_ready=1 only in IDLE.
- IDLE: on req_valid&&req_ready, latch we/ctr/addr/wdata.
  - Illegal ctr (011, 110, 111) -> DONE with err=1.
  - Misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0) -> DONE with err=1.
  - Otherwise -> ISSUE.
  - Errored requests never assert mem_req.
- Lane mapping, with off=addr[1:0]:
  - mem_addr = {addr[31:2],2'b00}.
  - mem_wmask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - mem_wdata = wdata<<(8*off), upper bits truncated.
  - mem_wmask=0 for loads.
- ISSUE: mem_req=1 for exactly this cycle, with mem_we/mem_addr/mem_wmask/mem_wdata driven from the latched request.
  - mem_ack this cycle -> DONE.
  - Otherwise -> WAIT.
- WAIT: mem_req=0; address/data/mask outputs held stable. On mem_ack -> DONE.
- Watchdog:
  - Counter cleared on IDLE->ISSUE; increments each ISSUE/WAIT cycle without ack.
  - On reaching TIMEOUT with no ack -> DONE with err=1.
  - mem_ack in the same cycle as the timeout wins: no error.
- Load extraction, on ack with sh=mem_rdata>>(8*off):
  - 000: sign-extend sh[7:0].
  - 100: zero-extend sh[7:0].
  - 001: sign-extend sh[15:0].
  - 101: zero-extend sh[15:0].
  - 010: full word.
  - Result is registered into resp_data on the ack edge.
- DONE: resp_valid=1; resp_data/resp_err held stable until resp_ready.
  - On resp_valid&&resp_ready -> IDLE; resp_valid drops next cycle.
  - resp_data/resp_err keep their value until the next DONE.
- Latency: legal op with mem_ack in the ISSUE cycle -> resp_valid 2 cycles after the accept edge. Error ops -> 1 cycle.
- No new request is accepted in the cycle a response is consumed; back-to-back throughput is one op per 3 cycles minimum.
- mem_ack outside ISSUE/WAIT is ignored.

Test Plan:
- Load byte signed: ctr=000, addr=0x8000_0003, mem_rdata=0x80AA_BBCC, ack in ISSUE -> mem_addr=0x8000_0000, mem_wmask=0, resp_data=0xFFFF_FF80, err=0, resp_valid 2 cycles after accept.
- Load halfword unsigned: ctr=101, addr=0x8000_0002, mem_rdata=0x9234_5678, ack after 3 WAIT cycles -> resp_data=0x0000_9234.
- Store byte: we=1, ctr=000, addr=0x8000_0101, wdata=0x1234_56EF -> one mem_req pulse, mem_addr=0x8000_0100, mem_wmask=4'b0010, mem_wdata=0x3456_EF00, resp_data=0.
- Misaligned word: ctr=010, addr=0x8000_0002; and illegal ctr=111 -> no mem_req, resp_err=1 one cycle after accept.
- Timeout with TIMEOUT=4: mem_ack never asserted -> resp_err=1 after 4 ISSUE/WAIT cycles. Repeat with ack on cycle 4 -> err=0.
- Backpressure plus reset: resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0. Assert rst_n=0 during WAIT -> mem_req=0, resp_valid=0, req_ready=1 immediately.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit between execute and the data-memory port.
// Lane-shifts stores, extends loads, and bounds memory waits with a watchdog.
module lsu_align #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wd_cnt;
    logic             lat_we;
    logic [2:0]       lat_ctr;
    logic [1:0]       lat_off;

    logic             ctr_ok;
    logic             aligned;
    logic [1:0]       off;
    logic [3:0]       wmask_n;
    logic [31:0]      wdata_n;
    logic [31:0]      sh;
    logic [31:0]      load_val;

    assign off       = req_addr[1:0];
    assign req_ready = (state == S_IDLE);
    assign mem_req   = (state == S_ISSUE);
    assign resp_valid = (state == S_DONE);

    always_comb begin
        ctr_ok  = 1'b0;
        aligned = 1'b0;
        wmask_n = 4'b0000;
        unique case (req_ctr)
            3'b000, 3'b100: begin
                ctr_ok  = 1'b1;
                aligned = 1'b1;
                wmask_n = 4'b0001 << off;
            end
            3'b001, 3'b101: begin
                ctr_ok  = 1'b1;
                aligned = ~off[0];
                wmask_n = 4'b0011 << off;
            end
            3'b010: begin
                ctr_ok  = 1'b1;
                aligned = (off == 2'b00);
                wmask_n = 4'b1111;
            end
            default: begin
                ctr_ok  = 1'b0;
                aligned = 1'b0;
                wmask_n = 4'b0000;
            end
        endcase
        if (!req_we) wmask_n = 4'b0000;
    end

    assign wdata_n = req_wdata << {off, 3'b000};
    assign sh      = mem_rdata >> {lat_off, 3'b000};

    always_comb begin
        load_val = 32'd0;
        unique case (lat_ctr)
            3'b000:  load_val = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_val = {24'd0, sh[7:0]};
            3'b001:  load_val = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_val = {16'd0, sh[15:0]};
            3'b010:  load_val = sh;
            default: load_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wd_cnt    <= '0;
            lat_we    <= 1'b0;
            lat_ctr   <= 3'b000;
            lat_off   <= 2'b00;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wmask <= 4'b0000;
            mem_wdata <= 32'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_ctr   <= req_ctr;
                        lat_off   <= off;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wmask <= wmask_n;
                        mem_wdata <= wdata_n;
                        if (!ctr_ok || !aligned) begin
                            state     <= S_DONE;
                            resp_err  <= 1'b1;
                            resp_data <= 32'd0;
                        end else begin
                            state  <= S_ISSUE;
                            wd_cnt <= '0;
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // An ack arriving on the timeout cycle still completes cleanly
                    if (mem_ack) begin
                        state     <= S_DONE;
                        resp_err  <= 1'b0;
                        resp_data <= lat_we ? 32'd0 : load_val;
                    end else if (wd_cnt == WD_LAST) begin
                        state     <= S_DONE;
                        resp_err  <= 1'b1;
                        resp_data <= 32'd0;
                    end else begin
                        state  <= S_WAIT;
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed cases plus random ops
// checked against an arithmetic reference of the load/store rules.
module tb_lsu_align;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    int n_chk = 0;
    int n_pass = 0;

    lsu_align #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_ctr(req_ctr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] ctr,
                                             input int off,
                                             input logic [31:0] rd);
        logic [31:0] sh, v;
        sh = rd / (32'd1 << (8 * off));
        case (ctr)
            3'b000: begin v = sh % 256;   if (v >= 128)   v = v - 32'd256;   end
            3'b100: v = sh % 256;
            3'b001: begin v = sh % 65536; if (v >= 32768) v = v - 32'd65536; end
            3'b101: v = sh % 65536;
            default: v = sh;
        endcase
        return v;
    endfunction

    task automatic do_op(input logic we, input logic [2:0] ctr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_at,
                         input int stall);
        int off;
        bit legal;
        bit done;
        int k;
        logic [31:0] e_data, e_mask, e_wd;
        logic e_err;
        off = int'(addr % 4);
        legal = (ctr == 3'b000 || ctr == 3'b001 || ctr == 3'b010 ||
                 ctr == 3'b100 || ctr == 3'b101);
        if ((ctr == 3'b001 || ctr == 3'b101) && (off % 2 != 0)) legal = 0;
        if (ctr == 3'b010 && off != 0) legal = 0;
        if (!we) e_mask = 0;
        else if (ctr == 3'b010) e_mask = 15;
        else if (ctr[1:0] == 2'b01) e_mask = 3 * (1 << off);
        else e_mask = 1 << off;
        e_wd = wd * (32'd1 << (8 * off));
        e_data = 0;
        e_err = 0;

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_we = we; req_ctr = ctr;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 0;
        req_addr = $urandom; req_wdata = $urandom;
        req_ctr = 3'($urandom); req_we = 1'($urandom);

        if (!legal) begin
            chk("err_no_mem_req", mem_req, 0);
            e_err = 1;
        end else begin
            done = 0;
            for (k = 1; !done; k++) begin
                chk("mem_req_pulse", mem_req, (k == 1) ? 1 : 0);
                chk("no_early_resp", resp_valid, 0);
                if (k == 1) begin
                    chk("mem_we", mem_we, we);
                    chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    chk("mem_wmask", mem_wmask, e_mask);
                    if (we) chk("mem_wdata", mem_wdata, e_wd);
                end else begin
                    chk("mem_addr_hold", mem_addr, addr & 32'hFFFF_FFFC);
                end
                mem_ack = (k == ack_at);
                mem_rdata = (k == ack_at) ? rd : $urandom;
                @(negedge clk);
                mem_ack = 0;
                if (k == ack_at) begin
                    done = 1;
                    e_data = we ? 0 : ref_load(ctr, off, rd);
                end else if (k == TO) begin
                    done = 1;
                    e_err = 1;
                end
            end
        end

        for (int s = 0; s <= stall; s++) begin
            chk("resp_valid", resp_valid, 1);
            chk("resp_data", resp_data, e_data);
            chk("resp_err", resp_err, e_err);
            chk("req_ready_busy", req_ready, 0);
            if (s < stall) @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        chk("resp_valid_drop", resp_valid, 0);
        chk("resp_data_keep", resp_data, e_data);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        logic [2:0] r_ctr;
        logic [31:0] r_addr;
        rst_n = 0; req_valid = 0; req_we = 0; req_ctr = 0;
        req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
        resp_ready = 0;
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        @(negedge clk);
        rst_n = 1;

        do_op(0, 3'b000, 32'h8000_0003, 0, 32'h80AA_BBCC, 1, 0);
        do_op(0, 3'b101, 32'h8000_0002, 0, 32'h9234_5678, 4, 0);
        do_op(1, 3'b000, 32'h8000_0101, 32'h1234_56EF, 0, 1, 0);
        do_op(0, 3'b010, 32'h8000_0002, 0, 0, 1, 0);
        do_op(0, 3'b111, 32'h8000_0000, 0, 0, 1, 0);
        do_op(0, 3'b010, 32'h8000_0010, 0, 32'hDEAD_BEEF, 0, 0);
        do_op(0, 3'b010, 32'h8000_0010, 0, 32'hDEAD_BEEF, 4, 0);
        do_op(1, 3'b001, 32'h0000_0006, 32'hAAAA_BEEF, 0, 2, 0);
        do_op(0, 3'b001, 32'h0000_0002, 0, 32'h8001_0000, 2, 5);

        // reset during ISSUE, then during WAIT
        @(negedge clk);
        req_valid = 1; req_we = 0; req_ctr = 3'b010; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 0;
        chk("pre_rst_issue", mem_req, 1);
        rst_n = 0;
        #1;
        chk("rst_issue_mem_req", mem_req, 0);
        chk("rst_issue_req_ready", req_ready, 1);
        chk("rst_issue_resp_valid", resp_valid, 0);
        chk("rst_issue_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_ctr = 3'b000; req_addr = 32'h41;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("pre_rst_wait_req_ready", req_ready, 0);
        rst_n = 0;
        #1;
        chk("rst_wait_mem_req", mem_req, 0);
        chk("rst_wait_req_ready", req_ready, 1);
        chk("rst_wait_resp_valid", resp_valid, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_resp", resp_valid, 0);
        end

        for (int i = 0; i < 60; i++) begin
            r_ctr = 3'($urandom);
            r_addr = $urandom;
            do_op(1'($urandom), r_ctr, r_addr, $urandom, $urandom,
                  $urandom_range(0, 5), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
